// File: rtl/prog_alu_seq.sv
// prog_alu_seq: byte-serial program loader feeding an instruction memory,
// plus a one-instruction-per-cycle accumulator sequencer with LOAD/RUN/HALT modes.
module prog_alu_seq #(
  parameter int DATAWIDTH   = 32,
  parameter int INSTR_WIDTH = 16,
  parameter int ADDWIDTH    = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_en,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_in,
  input  logic                 run_start,
  output logic [DATAWIDTH-1:0] result,
  output logic [ADDWIDTH-1:0]  pc,
  output logic                 busy,
  output logic                 halted,
  output logic                 zero,
  output logic                 carry
);

  localparam int DEPTH = 2 ** ADDWIDTH;
  localparam int NB    = INSTR_WIDTH / 8;
  localparam int CW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int IMMW  = INSTR_WIDTH - 4;
  // Working width for the immediate: wide enough for data and jump targets.
  localparam int EW0   = (IMMW > DATAWIDTH) ? IMMW : DATAWIDTH;
  localparam int EW    = (EW0 > ADDWIDTH) ? EW0 : ADDWIDTH;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HALT} state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_LDI  = 4'h1, OP_ADDI = 4'h2, OP_SUBI = 4'h3,
    OP_ANDI = 4'h4, OP_ORI  = 4'h5, OP_XORI = 4'h6, OP_SHLI = 4'h7,
    OP_SHRI = 4'h8, OP_JMP  = 4'h9, OP_JZ   = 4'hA, OP_JNZ  = 4'hB,
    OP_RSVC = 4'hC, OP_RSVD = 4'hD, OP_RSVE = 4'hE, OP_HALT = 4'hF
  } opcode_t;

  state_t                 state;
  logic [DATAWIDTH-1:0]   acc;
  logic [ADDWIDTH-1:0]    wr_ptr;
  logic [CW-1:0]          byte_cnt;
  logic [INSTR_WIDTH-1:0] asm_reg;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  logic [INSTR_WIDTH-1:0] asm_next;
  logic                   last_byte;
  logic                   mem_we;

  logic [INSTR_WIDTH-1:0] instr;
  opcode_t                opcode;
  logic [EW-1:0]          imm_w;
  logic [DATAWIDTH-1:0]   imm_d;
  logic [DATAWIDTH:0]     sum;
  logic [DATAWIDTH:0]     diff;
  logic [DATAWIDTH-1:0]   acc_nx;
  logic                   carry_nx;
  logic [ADDWIDTH-1:0]    pc_nx;
  logic                   halt_nx;

  assign result = acc;
  assign zero   = (acc == '0);

  // Merge the incoming byte into its lane so the last byte lands in the same cycle's write.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    asm_next = asm_reg;
    for (int i = 0; i < NB; i++) begin
      if (byte_cnt == CW'(i)) asm_next[i*8 +: 8] = byte_in;
    end
  end

  assign last_byte = (byte_cnt == CW'(NB - 1));
  assign mem_we    = (state == S_LOAD) && load_en && byte_valid && last_byte;

  // Instruction memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset, so it stays a plain RAM rather than a bank of reset flops.
    if (mem_we) mem[wr_ptr] <= asm_next;
  end

  // Decode and execute the instruction at pc (asynchronous read).
  always_comb begin
    instr    = mem[pc];
    opcode   = opcode_t'(instr[INSTR_WIDTH-1 -: 4]);
    imm_w    = EW'(instr[IMMW-1:0]);
    imm_d    = imm_w[DATAWIDTH-1:0];
    sum      = {1'b0, acc} + {1'b0, imm_d};
    diff     = {1'b0, acc} - {1'b0, imm_d};
    acc_nx   = acc;
    carry_nx = carry;
    pc_nx    = pc + 1'b1;
    halt_nx  = 1'b0;
    case (opcode)
      OP_LDI:  acc_nx = imm_d;
      OP_ADDI: {carry_nx, acc_nx} = sum;
      OP_SUBI: {carry_nx, acc_nx} = diff;
      OP_ANDI: acc_nx = acc & imm_d;
      OP_ORI:  acc_nx = acc | imm_d;
      OP_XORI: acc_nx = acc ^ imm_d;
      OP_SHLI: acc_nx = (imm_w >= EW'(DATAWIDTH)) ? '0 : (acc << imm_w);
      OP_SHRI: acc_nx = (imm_w >= EW'(DATAWIDTH)) ? '0 : (acc >> imm_w);
      OP_JMP:  pc_nx = imm_w[ADDWIDTH-1:0];
      OP_JZ:   if (acc == '0) pc_nx = imm_w[ADDWIDTH-1:0];
      OP_JNZ:  if (acc != '0) pc_nx = imm_w[ADDWIDTH-1:0];
      OP_HALT: begin
        halt_nx = 1'b1;
        pc_nx   = pc;
      end
      default: ;
    endcase
  end

  // Mode FSM with registered busy/halted; owns acc, pc, carry and the loader pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state    <= S_IDLE;
      acc      <= '0;
      pc       <= '0;
      wr_ptr   <= '0;
      byte_cnt <= '0;
      asm_reg  <= '0;
      carry    <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_en) begin
            state    <= S_LOAD;
            wr_ptr   <= '0;
            byte_cnt <= '0;
          end else if (run_start) begin
            state <= S_RUN;
            busy  <= 1'b1;
            pc    <= '0;
            acc   <= '0;
            carry <= 1'b0;
          end
        end
        S_LOAD: begin
          if (!load_en) begin
            // Any partial word is dropped; the next load restarts at address 0.
            state    <= S_IDLE;
            byte_cnt <= '0;
          end else if (byte_valid) begin
            asm_reg <= asm_next;
            if (last_byte) begin
              byte_cnt <= '0;
              wr_ptr   <= wr_ptr + 1'b1;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (load_en) begin
            // Abort: accumulator and pc are held, loader restarts.
            state    <= S_LOAD;
            busy     <= 1'b0;
            wr_ptr   <= '0;
            byte_cnt <= '0;
          end else begin
            acc   <= acc_nx;
            carry <= carry_nx;
            pc    <= pc_nx;
            if (halt_nx) begin
              state  <= S_HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
            end
          end
        end
        S_HALT: begin
          if (load_en) begin
            state    <= S_LOAD;
            halted   <= 1'b0;
            wr_ptr   <= '0;
            byte_cnt <= '0;
          end else if (run_start) begin
            state  <= S_RUN;
            halted <= 1'b0;
            busy   <= 1'b1;
            pc     <= '0;
            acc    <= '0;
            carry  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_alu_seq.sv
// tb_prog_alu_seq: directed and random programs checked against an ISA-level model.
module tb_prog_alu_seq;

  localparam int DW    = 32;
  localparam int IW    = 16;
  localparam int AW    = 7;
  localparam int DEPTH = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_en;
  logic          byte_valid;
  logic [7:0]    byte_in;
  logic          run_start;
  logic [DW-1:0] result;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
  logic          zero;
  logic          carry;

  int checks   = 0;
  int failures = 0;

  logic [IW-1:0] mem_m [DEPTH];
  logic [7:0]    prog_q [$];

  prog_alu_seq #(.DATAWIDTH(DW), .INSTR_WIDTH(IW), .ADDWIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_en    (load_en),
    .byte_valid (byte_valid),
    .byte_in    (byte_in),
    .run_start  (run_start),
    .result     (result),
    .pc         (pc),
    .busy       (busy),
    .halted     (halted),
    .zero       (zero),
    .carry      (carry)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic add_word(input logic [3:0] op, input logic [11:0] imm);
    prog_q.push_back(imm[7:0]);
    prog_q.push_back({op, imm[11:8]});
  endtask

  // Stream prog_q into the DUT and mirror complete words into the model memory.
  task automatic load_prog(input string tag);
    int            ptr  = 0;
    int            lane = 0;
    logic [IW-1:0] w    = '0;
    load_en   = 1'b1;
    run_start = 1'($urandom_range(1, 0));
    step();
    foreach (prog_q[i]) begin
      byte_valid = 1'b1;
      byte_in    = prog_q[i];
      run_start  = 1'($urandom_range(1, 0));
      step();
      if (lane == 0) begin
        w[7:0] = prog_q[i];
        lane   = 1;
      end else begin
        w[15:8]    = prog_q[i];
        mem_m[ptr] = w;
        ptr        = (ptr + 1) % DEPTH;
        lane       = 0;
      end
    end
    byte_valid = 1'b0;
    run_start  = 1'b0;
    load_en    = 1'b0;
    step();
    check({tag, ".load_busy"}, 64'(busy), 64'd0);
    check({tag, ".load_halted"}, 64'(halted), 64'd0);
    prog_q.delete();
  endtask

  // Instruction-set interpreter over the model memory, run from address 0.
  function automatic void model_run(output logic [DW-1:0] r_acc, output logic [AW-1:0] r_pc,
                                    output logic r_c, output int r_cycles);
    longint unsigned a    = 0;
    longint unsigned imm;
    longint unsigned mask = 64'hFFFF_FFFF;
    int              p    = 0;
    int              nxt;
    int              n    = 0;
    logic            c    = 1'b0;
    bit              done = 1'b0;
    logic [IW-1:0]   w;
    while (!done && n < 5000) begin
      w   = mem_m[p];
      imm = longint'(w[11:0]);
      nxt = (p + 1) % DEPTH;
      n++;
      case (w[15:12])
        4'h1: a = imm;
        4'h2: begin a = a + imm; c = (a > mask); a = a & mask; end
        4'h3: begin c = (imm > a); a = (a - imm) & mask; end
        4'h4: a = a & imm;
        4'h5: a = a | imm;
        4'h6: a = a ^ imm;
        4'h7: a = (imm >= 32) ? 0 : ((a << imm) & mask);
        4'h8: a = (imm >= 32) ? 0 : (a >> imm);
        4'h9: nxt = int'(imm) % DEPTH;
        4'hA: if (a == 0) nxt = int'(imm) % DEPTH;
        4'hB: if (a != 0) nxt = int'(imm) % DEPTH;
        4'hF: done = 1'b1;
        default: ;
      endcase
      if (!done) p = nxt;
    end
    r_acc    = a[31:0];
    r_pc     = AW'(p);
    r_c      = c;
    r_cycles = n;
  endfunction

  // Pulse run_start, count busy cycles, then compare the final state with the model.
  task automatic run_check(input string tag, output int cyc);
    logic [DW-1:0] e_acc;
    logic [AW-1:0] e_pc;
    logic          e_c;
    int            e_n;
    model_run(e_acc, e_pc, e_c, e_n);
    run_start = 1'b1;
    step();
    run_start = 1'b0;
    check({tag, ".busy_start"}, 64'(busy), 64'd1);
    cyc = 0;
    while (busy === 1'b1 && cyc < 1000) begin
      cyc++;
      step();
    end
    check({tag, ".cycles"}, 64'(cyc), 64'(e_n));
    check({tag, ".halted"}, 64'(halted), 64'd1);
    check({tag, ".busy_end"}, 64'(busy), 64'd0);
    check({tag, ".result"}, 64'(result), 64'(e_acc));
    check({tag, ".pc"}, 64'(pc), 64'(e_pc));
    check({tag, ".carry"}, 64'(carry), 64'(e_c));
    check({tag, ".zero"}, 64'(zero), 64'(e_acc == '0));
    step();
    step();
    check({tag, ".result_hold"}, 64'(result), 64'(e_acc));
    check({tag, ".pc_hold"}, 64'(pc), 64'(e_pc));
  endtask

  initial begin
    int            cyc;
    int            n;
    logic [3:0]    op;
    logic [11:0]   imm;
    logic [DW-1:0] hold;
    logic [3:0]    ops [14] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE};

    rst_n      = 1'b0;
    load_en    = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    run_start  = 1'b0;
    step();
    step();
    check("reset.result", 64'(result), 64'd0);
    check("reset.pc", 64'(pc), 64'd0);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.halted", 64'(halted), 64'd0);
    check("reset.zero", 64'(zero), 64'd1);
    check("reset.carry", 64'(carry), 64'd0);
    rst_n = 1'b1;
    step();

    // LDI 5; ADDI 3; HALT
    add_word(4'h1, 12'd5); add_word(4'h2, 12'd3); add_word(4'hF, 12'd0);
    load_prog("t1");
    run_check("t1", cyc);
    check("t1.const_cycles", 64'(cyc), 64'd3);
    check("t1.const_result", 64'(result), 64'd8);
    check("t1.const_pc", 64'(pc), 64'd2);
    // Re-run from HALT reproduces the same result.
    run_check("t1_rerun", cyc);

    // LDI 0; SUBI 1; HALT -> borrow
    add_word(4'h1, 12'd0); add_word(4'h3, 12'd1); add_word(4'hF, 12'd0);
    load_prog("t2");
    run_check("t2", cyc);
    check("t2.const_result", 64'(result), 64'hFFFF_FFFF);
    check("t2.const_carry", 64'(carry), 64'd1);

    // LDI 0; SUBI 1; ADDI 2; HALT -> add carry out
    add_word(4'h1, 12'd0); add_word(4'h3, 12'd1); add_word(4'h2, 12'd2); add_word(4'hF, 12'd0);
    load_prog("t2b");
    run_check("t2b", cyc);
    check("t2b.const_result", 64'(result), 64'd1);
    check("t2b.const_carry", 64'(carry), 64'd1);

    // LDI 3; SUBI 1; JNZ 1; HALT
    add_word(4'h1, 12'd3); add_word(4'h3, 12'd1); add_word(4'hB, 12'd1); add_word(4'hF, 12'd0);
    load_prog("t3");
    run_check("t3", cyc);
    check("t3.const_cycles", 64'(cyc), 64'd8);
    check("t3.const_pc", 64'(pc), 64'd3);
    check("t3.const_zero", 64'(zero), 64'd1);

    // Partial word must not be written; second load restarts at address 0.
    add_word(4'h1, 12'd1); add_word(4'h2, 12'd2); add_word(4'hF, 12'd0);
    load_prog("t4a");
    add_word(4'h0, 12'd0); prog_q.push_back(8'hFF);
    load_prog("t4b");
    run_check("t4b", cyc);
    check("t4b.const_result", 64'(result), 64'd2);
    check("t4b.const_pc", 64'(pc), 64'd2);
    add_word(4'hF, 12'd0);
    load_prog("t4c");
    run_check("t4c", cyc);
    check("t4c.const_pc", 64'(pc), 64'd0);
    check("t4c.const_cycles", 64'(cyc), 64'd1);

    // 129 words: the 129th (HALT) wraps onto address 0.
    for (int i = 0; i < DEPTH; i++) add_word(4'h1, 12'($urandom));
    add_word(4'hF, 12'd0);
    load_prog("t5");
    run_check("t5", cyc);
    check("t5.const_pc", 64'(pc), 64'd0);
    check("t5.const_cycles", 64'(cyc), 64'd1);

    // Random forward-only programs ending in HALT.
    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(10, 2);
      for (int i = 0; i < n; i++) begin
        op = ops[$urandom_range(13, 0)];
        if (op == 4'h9 || op == 4'hA || op == 4'hB)
          imm = 12'($urandom_range(n, i + 1));
        else if (op == 4'h7 || op == 4'h8)
          imm = ($urandom_range(3, 0) == 0) ? 12'($urandom) : 12'($urandom_range(40, 0));
        else
          imm = 12'($urandom);
        add_word(op, imm);
      end
      add_word(4'hF, 12'd0);
      load_prog($sformatf("rnd%0d", t));
      run_check($sformatf("rnd%0d", t), cyc);
    end

    // load_en aborts a running program and holds the accumulator.
    add_word(4'h1, 12'd5); add_word(4'h2, 12'd1); add_word(4'h9, 12'd1);
    load_prog("abort");
    run_start = 1'b1;
    step();
    run_start = 1'b0;
    repeat (5) step();
    check("abort.busy_running", 64'(busy), 64'd1);
    hold    = result;
    load_en = 1'b1;
    step();
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.result_held", 64'(result), 64'(hold));
    load_en = 1'b0;
    step();
    check("abort.result_idle", 64'(result), 64'(hold));

    // Asynchronous reset in the middle of a run.
    add_word(4'h1, 12'd3); add_word(4'h3, 12'd1); add_word(4'hB, 12'd1); add_word(4'hF, 12'd0);
    load_prog("t6");
    run_start = 1'b1;
    step();
    run_start = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("t6.rst_result", 64'(result), 64'd0);
    check("t6.rst_pc", 64'(pc), 64'd0);
    check("t6.rst_busy", 64'(busy), 64'd0);
    check("t6.rst_halted", 64'(halted), 64'd0);
    check("t6.rst_zero", 64'(zero), 64'd1);
    #1 rst_n = 1'b1;
    step();
    run_check("t6_rerun", cyc);
    check("t6.const_cycles", 64'(cyc), 64'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
